// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER MEM-stage load/store unit.
// Access sizes, FSM states, size decoding and the alignment rule.
package otter_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } lsu_state_t;

   // The raw encoding 2'b11 behaves as a word access.
   function automatic mem_size_t decode_size(input logic [1:0] raw);
      mem_size_t sz;
      case (raw)
         2'b00:   sz = SZ_BYTE;
         2'b01:   sz = SZ_HALF;
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_HALF: mis = off[0];
         SZ_WORD: mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replicated write data,
// plus load byte/half extraction with sign or zero extension.
module lsu_align
   import otter_mem_pkg::*;
(
   input  mem_size_t   st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  mem_size_t   ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Sub-word offsets are masked to the access size so unaligned addresses fall back to aligned lanes.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_size)
         SZ_BYTE: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_be    = 4'b0011 << {st_off[1], 1'b0};
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_off)
         2'b00:   byte_sel = ld_rdata[7:0];
         2'b01:   byte_sel = ld_rdata[15:8];
         2'b10:   byte_sel = ld_rdata[23:16];
         default: byte_sel = ld_rdata[31:24];
      endcase
      half_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      ld_data  = ld_rdata;
      case (ld_size)
         SZ_BYTE: ld_data = ld_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_HALF: ld_data = ld_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// OTTER MEM-stage load/store unit: one REQ/ACK bus transaction per load/store, stalling until done.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_stage_lsu
   import otter_mem_pkg::*;
#(
   parameter int ACK_TIMEOUT = 256
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        VALID_MEM,
   input  logic        MEM_READ_MEM,
   input  logic        MEM_WRITE_MEM,
   input  logic [1:0]  SIZE_MEM,
   input  logic        SIGN_MEM,
   input  logic [31:0] ALU_RESULT_MEM,
   input  logic [31:0] RS2_MEM,
   output logic        DBUS_REQ,
   output logic        DBUS_WE,
   output logic [31:0] DBUS_ADDR,
   output logic [3:0]  DBUS_BE,
   output logic [31:0] DBUS_WDATA,
   input  logic        DBUS_ACK,
   input  logic [31:0] DBUS_RDATA,
   output logic        STALL_MEM,
   output logic [31:0] LOAD_DATA_MEM,
   output logic        LOAD_VALID,
   output logic        BUS_ERR,
   output logic        MISALIGN_ERR
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   lsu_state_t  state, state_d;
   mem_size_t   req_size, size_q;
   logic        access, misalign_now, timeout_hit, stall;
   logic [3:0]  st_be, be_q;
   logic [31:0] st_wdata, ld_data, addr_q, wdata_q, load_q;
   logic [1:0]  off_q;
   logic        we_q, is_load_q, sign_q, err_q, mis_q;
   logic [CW-1:0] cnt;

   assign access   = VALID_MEM & (MEM_READ_MEM | MEM_WRITE_MEM);
   assign req_size = decode_size(SIZE_MEM);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_now = is_misaligned(req_size, ALU_RESULT_MEM[1:0]);
`else
   assign misalign_now = 1'b0;
`endif

   assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt == CW'(ACK_TIMEOUT - 1));

   lsu_align u_align (
      .st_size     (req_size),
      .st_off      (ALU_RESULT_MEM[1:0]),
      .st_data     (RS2_MEM),
      .st_be       (st_be),
      .st_wdata    (st_wdata),
      .ld_size     (size_q),
      .ld_off      (off_q),
      .ld_unsigned (sign_q),
      .ld_rdata    (DBUS_RDATA),
      .ld_data     (ld_data)
   );

   always_comb begin
      state_d = state;
      stall   = 1'b0;
      case (state)
         IDLE: if (access) begin
            stall   = 1'b1;
            state_d = misalign_now ? DONE : BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (DBUS_ACK || timeout_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A store wins when READ and WRITE are both set; the request is frozen at IDLE exit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         is_load_q <= 1'b0;
         size_q    <= SZ_BYTE;
         off_q     <= '0;
         sign_q    <= 1'b0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
         cnt       <= '0;
         load_q    <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && access) begin
            addr_q    <= {ALU_RESULT_MEM[31:2], 2'b00};
            be_q      <= st_be;
            wdata_q   <= st_wdata;
            we_q      <= MEM_WRITE_MEM;
            is_load_q <= ~MEM_WRITE_MEM;
            size_q    <= req_size;
            off_q     <= ALU_RESULT_MEM[1:0];
            sign_q    <= SIGN_MEM;
            mis_q     <= misalign_now;
            err_q     <= 1'b0;
            cnt       <= '0;
         end
         if (state == BUSY) begin
            if (DBUS_ACK) begin
               if (is_load_q) load_q <= ld_data;
            end else if (timeout_hit) begin
               err_q <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Reset gating keeps the combinational IDLE stall low while the unit is held in reset.
   assign STALL_MEM     = stall & RST_N;
   assign DBUS_REQ      = (state == BUSY);
   assign DBUS_WE       = we_q;
   assign DBUS_ADDR     = addr_q;
   assign DBUS_BE       = be_q;
   assign DBUS_WDATA    = wdata_q;
   assign LOAD_VALID    = (state == DONE) & is_load_q & ~err_q & ~mis_q;
   assign BUS_ERR       = (state == DONE) & err_q;
   assign MISALIGN_ERR  = (state == DONE) & mis_q;
   assign LOAD_DATA_MEM = ((state == DONE) && err_q) ? 32'h0 : load_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (ACK_TIMEOUT = 4).
// Expectations for the misaligned word load follow LSU_MISALIGN_TRAP_EN when defined.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, sign = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] alu_result = '0, rs2 = '0, dbus_rdata = '0;
   logic        dbus_ack = 1'b0;
   logic        dbus_req, dbus_we, stall, load_valid, bus_err, misalign_err;
   logic [31:0] dbus_addr, dbus_wdata, load_data;
   logic [3:0]  dbus_be;

   int n_asserts = 0;
   int n_fail = 0;

   int          obs_stall, obs_req, obs_lv, obs_berr, obs_mis;
   logic [31:0] obs_addr, obs_wdata, obs_ld;
   logic [3:0]  obs_be;
   logic        obs_we, obs_done;

   mem_stage_lsu #(.ACK_TIMEOUT(4)) dut (
      .CLK(clk), .RST_N(rst_n), .VALID_MEM(valid), .MEM_READ_MEM(mem_read),
      .MEM_WRITE_MEM(mem_write), .SIZE_MEM(size), .SIGN_MEM(sign),
      .ALU_RESULT_MEM(alu_result), .RS2_MEM(rs2), .DBUS_REQ(dbus_req),
      .DBUS_WE(dbus_we), .DBUS_ADDR(dbus_addr), .DBUS_BE(dbus_be),
      .DBUS_WDATA(dbus_wdata), .DBUS_ACK(dbus_ack), .DBUS_RDATA(dbus_rdata),
      .STALL_MEM(stall), .LOAD_DATA_MEM(load_data), .LOAD_VALID(load_valid),
      .BUS_ERR(bus_err), .MISALIGN_ERR(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Entered just after a rising edge in IDLE; returns just after the edge that leaves DONE.
   task automatic mem_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] data, input int waits,
                             input logic [31:0] rdata, input bit never_ack);
      valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign = sg;
      alu_result = addr; rs2 = data; dbus_ack = 1'b0; dbus_rdata = 32'hA5A5A5A5;
      obs_stall = 0; obs_req = 0; obs_lv = 0; obs_berr = 0; obs_mis = 0;
      obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0; obs_ld = '0; obs_done = 1'b0;
      for (int cyc = 0; cyc < 40 && !obs_done; cyc++) begin
         @(negedge clk);
         if (stall) obs_stall++;
         if (load_valid) obs_lv++;
         if (bus_err) obs_berr++;
         if (misalign_err) obs_mis++;
         if (dbus_req) begin
            obs_req++;
            if (obs_req == 1) begin
               obs_addr = dbus_addr; obs_be = dbus_be; obs_wdata = dbus_wdata; obs_we = dbus_we;
            end
         end
         if (!stall) begin
            obs_done = 1'b1;
            obs_ld = load_data;
         end
         dbus_ack   = dbus_req && !never_ack && (obs_req > waits);
         dbus_rdata = dbus_ack ? rdata : 32'hA5A5A5A5;
         @(posedge clk); #1;
         dbus_ack = 1'b0;
      end
      valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      check_output("completed", {31'b0, obs_done}, 32'd1);
   endtask

   initial begin
      $display("[TB] start");
      #12;
      check_output("reset_req", {31'b0, dbus_req}, 32'd0);
      check_output("reset_stall", {31'b0, stall}, 32'd0);
      check_output("reset_ld", load_data, 32'd0);
      check_output("reset_flags", {29'b0, load_valid, bus_err, misalign_err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LB 0x103, two wait states
      mem_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 2, 32'h80FF0000, 1'b0);
      check_output("lb_addr", obs_addr, 32'h100);
      check_output("lb_be", {28'b0, obs_be}, 32'b1000);
      check_output("lb_we", {31'b0, obs_we}, 32'd0);
      check_output("lb_stall", obs_stall, 32'd4);
      check_output("lb_req", obs_req, 32'd3);
      check_output("lb_lv", obs_lv, 32'd1);
      check_output("lb_data", obs_ld, 32'hFFFFFF80);

      mem_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 2, 32'h80FF0000, 1'b0);
      check_output("lbu_data", obs_ld, 32'h00000080);

      // SH 0x202, immediate ACK
      mem_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 0, 32'h0, 1'b0);
      check_output("sh_we", {31'b0, obs_we}, 32'd1);
      check_output("sh_addr", obs_addr, 32'h200);
      check_output("sh_be", {28'b0, obs_be}, 32'b1100);
      check_output("sh_wdata", obs_wdata, 32'hABCDABCD);
      check_output("sh_lv", obs_lv, 32'd0);
      check_output("sh_stall", obs_stall, 32'd2);
      check_output("ld_hold", load_data, 32'h00000080);

      // SB 0x001 with READ also high: treated as a store
      mem_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h001, 32'h000000AB, 0, 32'h0, 1'b0);
      check_output("sb_we", {31'b0, obs_we}, 32'd1);
      check_output("sb_be", {28'b0, obs_be}, 32'b0010);
      check_output("sb_wdata", obs_wdata, 32'hABABABAB);
      check_output("sb_lv", obs_lv, 32'd0);

      // LH 0x002 signed
      mem_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h002, 32'h0, 1, 32'h80017FFF, 1'b0);
      check_output("lh_be", {28'b0, obs_be}, 32'b1100);
      check_output("lh_data", obs_ld, 32'hFFFF8001);

      // LW 0x40, ACK in first BUSY cycle
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 1'b0);
      check_output("lw_stall", obs_stall, 32'd2);
      check_output("lw_be", {28'b0, obs_be}, 32'b1111);
      check_output("lw_lv", obs_lv, 32'd1);
      check_output("lw_data", obs_ld, 32'hDEADBEEF);

      // ACK while idle must not start anything
      dbus_ack = 1'b1;
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      @(negedge clk);
      check_output("idle_ack_req", {31'b0, dbus_req}, 32'd0);
      check_output("idle_ack_lv", {31'b0, load_valid}, 32'd0);
      @(posedge clk); #1;

      // Timeout: no ACK ever
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0, 32'h0, 1'b1);
      check_output("to_req", obs_req, 32'd4);
      check_output("to_berr", obs_berr, 32'd1);
      check_output("to_stall", obs_stall, 32'd5);
      check_output("to_lv", obs_lv, 32'd0);
      check_output("to_ld", obs_ld, 32'd0);

      // LW 0x101
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h11223344, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      check_output("mis_req", obs_req, 32'd0);
      check_output("mis_err", obs_mis, 32'd1);
      check_output("mis_stall", obs_stall, 32'd1);
      check_output("mis_lv", obs_lv, 32'd0);
`else
      check_output("mis_addr", obs_addr, 32'h100);
      check_output("mis_be", {28'b0, obs_be}, 32'b1111);
      check_output("mis_err", obs_mis, 32'd0);
      check_output("mis_data", obs_ld, 32'h11223344);
`endif

      // Reset while BUSY
      valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; alu_result = 32'h20;
      @(posedge clk); #1;
      @(negedge clk);
      check_output("pre_rst_req", {31'b0, dbus_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_req", {31'b0, dbus_req}, 32'd0);
      check_output("rst_stall", {31'b0, stall}, 32'd0);
      check_output("rst_ld", load_data, 32'd0);
      valid = 1'b0; mem_read = 1'b0;
      #4 rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back LW / SW
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1, 32'hCAFEF00D, 1'b0);
      check_output("b2b_lw_stall", obs_stall, 32'd3);
      check_output("b2b_lw_data", obs_ld, 32'hCAFEF00D);
      mem_access(1'b0, 1'b1, 2'b11, 1'b0, 32'hC, 32'h55667788, 0, 32'h0, 1'b0);
      check_output("b2b_sw_addr", obs_addr, 32'hC);
      check_output("b2b_sw_be", {28'b0, obs_be}, 32'b1111);
      check_output("b2b_sw_wdata", obs_wdata, 32'h55667788);
      check_output("b2b_sw_we", {31'b0, obs_we}, 32'd1);
      check_output("b2b_ld_hold", load_data, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
